// File: rtl/obd_frame_tx.sv
// OBD telemetry frame transmitter: snapshots vehicle values and sends them as 8N1 UART bytes.
// Define OBD_CHECKSUM_EN to append the XOR checksum byte (12-byte frame); otherwise 11 bytes.
module obd_frame_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_req,
    input  logic        engine_on,
    input  logic [7:0]  speed,
    input  logic [13:0] rpm,
    input  logic [7:0]  fuel,
    input  logic [7:0]  temp,
    input  logic [31:0] odometer_raw,
    input  logic        ess_trigger,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

`ifdef OBD_CHECKSUM_EN
    localparam int NBYTES = 12;
`else
    localparam int NBYTES = 11;
`endif

    localparam logic [2:0]  S_IDLE  = 3'd0;
    localparam logic [2:0]  S_START = 3'd1;
    localparam logic [2:0]  S_DATA  = 3'd2;
    localparam logic [2:0]  S_STOP  = 3'd3;
    localparam logic [2:0]  S_DONE  = 3'd4;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  BYTE_LAST = 4'(NBYTES - 1);

    logic [2:0]              state_q, state_d;
    logic [15:0]             baud_q, baud_d;
    logic [2:0]              bit_q, bit_d;
    logic [3:0]              byte_q, byte_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    overrun_q, overrun_d;
    logic                    ess_q, ess_d;
    logic [NBYTES-1:0][7:0]  buf_q, buf_d;
    logic [10:0][7:0]        payload_s;
    logic [NBYTES-1:0][7:0]  frame_s;
    logic [7:0]              cur_byte_s;
    logic [2:0]              nxt_bit_s;
    logic                    snap_s;
    logic                    baud_end_s;

    always_comb begin
        payload_s     = '0;
        payload_s[0]  = 8'hAA;
        payload_s[1]  = {6'b000000, ess_q | ess_trigger, engine_on};
        payload_s[2]  = speed;
        payload_s[3]  = {2'b00, rpm[13:8]};
        payload_s[4]  = rpm[7:0];
        payload_s[5]  = fuel;
        payload_s[6]  = temp;
        payload_s[7]  = odometer_raw[31:24];
        payload_s[8]  = odometer_raw[23:16];
        payload_s[9]  = odometer_raw[15:8];
        payload_s[10] = odometer_raw[7:0];
    end

`ifdef OBD_CHECKSUM_EN
    // Sync byte is excluded from the checksum.
    function automatic logic [7:0] xor_checksum(input logic [10:0][7:0] p);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 1; i < 11; i++) begin
            acc = acc ^ p[i];
        end
        return acc;
    endfunction

    assign frame_s = {xor_checksum(payload_s), payload_s};
`else
    assign frame_s = payload_s;
`endif

    assign snap_s     = (state_q == S_IDLE) && send_req;
    assign baud_end_s = (baud_q == BAUD_LAST);
    assign cur_byte_s = buf_q[byte_q];
    assign nxt_bit_s  = bit_q + 3'd1;
    assign ess_d      = snap_s ? ess_trigger : (ess_q | ess_trigger);
    assign buf_d      = snap_s ? frame_s : buf_q;

    // tx_d is the line level of the state being entered, so tx stays registered.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        overrun_d = send_req && (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (send_req) begin
                    state_d = S_START;
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    byte_d  = 4'd0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            end
            S_START: begin
                if (baud_end_s) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                    tx_d    = cur_byte_s[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_end_s) begin
                    baud_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = nxt_bit_s;
                        tx_d  = cur_byte_s[nxt_bit_s];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (baud_end_s) begin
                    baud_d = 16'd0;
                    if (byte_q == BYTE_LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        byte_d  = byte_q + 4'd1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters, outputs, ESS latch and frame buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= 16'd0;
            bit_q     <= 3'd0;
            byte_q    <= 4'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            ess_q     <= 1'b0;
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            ess_q     <= ess_d;
            buf_q     <= buf_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_obd_frame_tx.sv
// Bench for obd_frame_tx: UART decoder monitor plus a frame model built from the field rules.
module tb_obd_frame_tx;

    localparam int CPB = 4;
`ifdef OBD_CHECKSUM_EN
    localparam int NB = 12;
`else
    localparam int NB = 11;
`endif
    localparam int FRAME_CYC = 10 * NB * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        send_req = 1'b0;
    logic        engine_on = 1'b0;
    logic [7:0]  speed = 8'd0;
    logic [13:0] rpm = 14'd0;
    logic [7:0]  fuel = 8'd0;
    logic [7:0]  temp = 8'd0;
    logic [31:0] odometer_raw = 32'd0;
    logic        ess_trigger = 1'b0;
    logic        tx, busy, frame_done, overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int ovr_cnt = 0;
    int fe_cnt = 0;
    int busy_run = 0;
    int busy_len = 0;
    int d0 = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_b [NB];
    logic       ess_m = 1'b0;

    obd_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .send_req(send_req), .engine_on(engine_on),
        .speed(speed), .rpm(rpm), .fuel(fuel), .temp(temp),
        .odometer_raw(odometer_raw), .ess_trigger(ess_trigger),
        .tx(tx), .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Monitor: counts pulses, measures busy length, decodes UART bytes mid-bit.
    initial begin
        bit         dec_act;
        int         dec_cnt;
        int         k;
        logic [7:0] dec_sh;
        dec_act = 1'b0;
        dec_cnt = 0;
        dec_sh  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                dec_act  = 1'b0;
                busy_run = 0;
            end else begin
                if (frame_done) done_cnt++;
                if (overrun) ovr_cnt++;
                if (busy) busy_run++;
                else if (busy_run > 0) begin
                    busy_len = busy_run;
                    busy_run = 0;
                end
                if (!dec_act) begin
                    if (tx == 1'b0) begin
                        dec_act = 1'b1;
                        dec_cnt = 0;
                    end
                end else begin
                    dec_cnt++;
                end
                if (dec_act && (dec_cnt % CPB) == CPB / 2) begin
                    k = dec_cnt / CPB;
                    if (k == 0) begin
                        if (tx !== 1'b0) fe_cnt++;
                    end else if (k <= 8) begin
                        dec_sh[k-1] = tx;
                    end else begin
                        if (tx !== 1'b1) fe_cnt++;
                        rx_q.push_back(dec_sh);
                        dec_act = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame straight from the field layout; checksum is XOR of bytes 1..10.
    task automatic build_expected();
        logic [7:0] acc;
        exp_b[0]  = 8'hAA;
        exp_b[1]  = {6'd0, ess_m | ess_trigger, engine_on};
        exp_b[2]  = speed;
        exp_b[3]  = {2'b00, rpm[13:8]};
        exp_b[4]  = rpm[7:0];
        exp_b[5]  = fuel;
        exp_b[6]  = temp;
        exp_b[7]  = odometer_raw[31:24];
        exp_b[8]  = odometer_raw[23:16];
        exp_b[9]  = odometer_raw[15:8];
        exp_b[10] = odometer_raw[7:0];
        acc = 8'h00;
        for (int i = 1; i <= 10; i++) acc = acc ^ exp_b[i];
`ifdef OBD_CHECKSUM_EN
        exp_b[11] = acc;
`endif
    endtask

    task automatic ess_pulse();
        ess_trigger = 1'b1;
        tick();
        ess_trigger = 1'b0;
        ess_m = 1'b1;
        tick();
    endtask

    task automatic start_frame(input string tag);
        d0 = done_cnt;
        rx_q.delete();
        build_expected();
        send_req = 1'b1;
        ess_m = ess_trigger;
        tick();
        send_req = 1'b0;
        ess_trigger = 1'b0;
        check({tag, "_lat_busy"}, 32'(busy), 32'd1);
        check({tag, "_lat_tx"}, 32'(tx), 32'd0);
    endtask

    task automatic finish_frame(input string tag);
        logic [31:0] obs;
        for (int i = 0; i < FRAME_CYC + 20 && done_cnt == d0; i++) tick();
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'(d0 + 1));
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_busy_len"}, 32'(busy_len), 32'(FRAME_CYC));
        check({tag, "_nbytes"}, 32'(rx_q.size()), 32'(NB));
        for (int i = 0; i < NB; i++) begin
            obs = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF;
            check($sformatf("%s_byte%0d", tag, i), obs, 32'(exp_b[i]));
        end
    endtask

    initial begin
        int o0;
        int dd;
        ticks(3);
        rst = 1'b0;
        tick();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);

        // Basic frame
        engine_on = 1'b1; speed = 8'd100; rpm = 14'd2700; fuel = 8'd87;
        temp = 8'd90; odometer_raw = 32'h0001_2345; ess_trigger = 1'b0;
        start_frame("basic");
        finish_frame("basic");
        check("basic_last", 32'(rx_q[rx_q.size()-1]), (NB == 12) ? 32'h89 : 32'h45);

        // Snapshot isolation, requested back-to-back on the first IDLE cycle
        tick();
        start_frame("snap");
        speed = 8'd0; rpm = 14'd800;
        finish_frame("snap");
        check("snap_speed", 32'(rx_q[2]), 32'h64);

        // ESS latch
        speed = 8'd100; rpm = 14'd2700;
        tick();
        ess_pulse();
        start_frame("ess1");
        finish_frame("ess1");
        check("ess1_flags", 32'(rx_q[1]), 32'h03);
        tick();
        start_frame("ess2");
        finish_frame("ess2");
        check("ess2_flags", 32'(rx_q[1]), 32'h01);

        // Overrun mid-frame
        tick();
        o0 = ovr_cnt;
        start_frame("ovr");
        ticks(100);
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
        finish_frame("ovr");
        check("ovr_cnt", 32'(ovr_cnt), 32'(o0 + 1));
        dd = done_cnt;
        ticks(20);
        check("ovr_no_frame_busy", 32'(busy), 32'd0);
        check("ovr_no_frame_done", 32'(done_cnt), 32'(dd));
        check("ovr_no_frame_rx", 32'(rx_q.size()), 32'(NB));

        // Request during the DONE cycle is dropped
        start_frame("dreq");
        finish_frame("dreq");
        o0 = ovr_cnt;
        dd = done_cnt;
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
        ticks(10);
        check("dreq_ovr", 32'(ovr_cnt), 32'(o0 + 1));
        check("dreq_busy", 32'(busy), 32'd0);
        check("dreq_done", 32'(done_cnt), 32'(dd));

        // Reset during data bits of byte 3
        ess_pulse();
        start_frame("rstm");
        ticks(130);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ess_m = 1'b0;
        check("rstm_tx", 32'(tx), 32'd1);
        check("rstm_busy", 32'(busy), 32'd0);
        ticks(FRAME_CYC);
        check("rstm_no_done", 32'(done_cnt), 32'(d0));
        start_frame("post_rst");
        finish_frame("post_rst");

        // Randomized frames against the model
        for (int r = 0; r < 6; r++) begin
            ticks(1 + $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) ess_pulse();
            engine_on    = 1'($urandom_range(0, 1));
            speed        = 8'($urandom);
            rpm          = 14'($urandom);
            fuel         = 8'($urandom);
            temp         = 8'($urandom);
            odometer_raw = $urandom;
            ess_trigger  = ($urandom_range(0, 3) == 0);
            start_frame($sformatf("rnd%0d", r));
            speed        = 8'($urandom);
            rpm          = 14'($urandom);
            odometer_raw = $urandom;
            finish_frame($sformatf("rnd%0d", r));
        end

        check("framing_errors", 32'(fe_cnt), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
